// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared mode encoding and sizing helper for the multi-channel
// clock divider.
package clk_div_pkg;

   // Output style of one channel: free-running 50% square wave or a
   // one-cycle tick enable.
   typedef enum logic {
      MODE_SQUARE = 1'b0,
      MODE_TICK   = 1'b1
   } mode_e;

   // Width of a channel index. It is never narrower than one bit, so a
   // single-channel build still has a legal cfg_ch port.
   function automatic int ch_width(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel. It holds the period counter, the active
// divisor and mode, and a one-deep pending config slot that is swapped in at
// the channel's next terminal count (or on the next edge while disabled).
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int CNT_W    = 27,
   parameter int DIV_INIT = 100
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_div,
   input  logic             wr_mode,
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);

   // A divisor of zero would never reach a terminal count, so it is treated
   // as divide-by-one both here and on every config load.
   localparam logic [CNT_W-1:0] DIV_RST = (DIV_INIT < 1) ? CNT_W'(1) : CNT_W'(DIV_INIT);

   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [CNT_W-1:0] div_q,      div_d;
   mode_e            mode_q,     mode_d;
   logic             pend_q,     pend_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   mode_e            pend_mode_q, pend_mode_d;
   logic             clk_out_q,  clk_out_d;
   logic             tick_q,     tick_d;

   logic             terminal;
   logic             apply;

   // Last count of the current period; div_q is always at least one.
   assign terminal = (cnt_q == div_q - CNT_W'(1));

   // A pending config takes over at a terminal count, or at once while the
   // channel is stopped, since a stopped channel has no period to finish.
   assign apply = pend_q && (!en || terminal);

   // Next-state logic: count, produce the output event, swap in a pending
   // config, then capture a newly accepted config.
   always_comb begin
      // NOTE: every signal gets a default before any branch; a path that
      // leaves one unassigned would infer a latch.
      cnt_d       = cnt_q;
      div_d       = div_q;
      mode_d      = mode_q;
      pend_d      = pend_q;
      pend_div_d  = pend_div_q;
      pend_mode_d = pend_mode_q;
      clk_out_d   = clk_out_q;
      tick_d      = 1'b0;

      if (en) begin
         if (terminal) begin
            cnt_d = '0;
            // The period that just ended belongs to the old mode, so the
            // old mode decides which output fires at this edge.
            if (mode_q == MODE_SQUARE) begin
               clk_out_d = ~clk_out_q;
            end else begin
               tick_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (apply) begin
         div_d  = pend_div_q;
         mode_d = pend_mode_q;
         cnt_d  = '0;
         pend_d = 1'b0;
         // Switching style restarts the square output low so a tick channel
         // never carries a stale high level.
         if (pend_mode_q != mode_q) begin
            clk_out_d = 1'b0;
         end
      end

      // The top only strobes wr_en while pend_q is clear, so a capture here
      // never collides with an apply in the same cycle. A config accepted at
      // a terminal therefore waits for the following terminal.
      if (wr_en) begin
         pend_d      = 1'b1;
         pend_div_d  = (wr_div == '0) ? CNT_W'(1) : wr_div;
         pend_mode_d = mode_e'(wr_mode);
      end
   end

   // State register; reset drops any pending config and clears both outputs.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         div_q       <= DIV_RST;
         mode_q      <= MODE_SQUARE;
         pend_q      <= 1'b0;
         pend_div_q  <= DIV_RST;
         pend_mode_q <= MODE_SQUARE;
         clk_out_q   <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling the
         // pre-edge values, independent of statement order.
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         mode_q      <= mode_d;
         pend_q      <= pend_d;
         pend_div_q  <= pend_div_d;
         pend_mode_q <= pend_mode_d;
         clk_out_q   <= clk_out_d;
         tick_q      <= tick_d;
      end
   end

   assign pending = pend_q;
   assign clk_out = clk_out_q;
   assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable clock dividers sharing one
// valid/ready config port. The top decodes the config target, derives
// cfg_ready from that channel's pending flag and strobes one channel.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 27,
   parameter int DIV_INIT = 100,
   parameter int CH_W     = ch_width(NUM_CH)
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   input  logic [NUM_CH-1:0] en,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   // Every encodable channel index gets a slot; slots past NUM_CH never
   // report pending, so transfers to them are accepted and dropped.
   localparam int SLOTS = 2 ** CH_W;

   logic [NUM_CH-1:0] pending;
   logic [SLOTS-1:0]  pend_slot;
   logic              cfg_fire;
   logic [NUM_CH-1:0] wr_en;

   for (genvar g = 0; g < SLOTS; g++) begin : g_slot
      if (g < NUM_CH) begin : g_real
         assign pend_slot[g] = pending[g];
      end else begin : g_pad
         assign pend_slot[g] = 1'b0;
      end
   end

   // A channel with an unapplied config refuses another until it applies.
   assign cfg_ready = ~pend_slot[cfg_ch];
   assign cfg_fire  = cfg_valid && cfg_ready;

   // One-hot write strobe to the addressed channel on an accepted transfer.
   always_comb begin
      wr_en = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_en[i] = cfg_fire && (cfg_ch == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_chan #(
         .CNT_W    (CNT_W),
         .DIV_INIT (DIV_INIT)
      ) u_chan (
         .clk_in  (clk_in),
         .rst_n   (rst_n),
         .en      (en[g]),
         .wr_en   (wr_en[g]),
         .wr_div  (cfg_div),
         .wr_mode (cfg_mode),
         .pending (pending[g]),
         .clk_out (clk_out[g]),
         .tick    (tick[g])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: table of config/enable vectors with expected cfg_ready,
// plus a per-edge scoreboard of expected {tick, clk_out} for the scenario.
module tb_clk_div_multi;
   import clk_div_pkg::*;

   localparam int NUM_CH   = 4;
   localparam int CNT_W    = 27;
   localparam int DIV_INIT = 100;
   localparam int CH_W     = 2;

   logic              clk_in = 1'b0;
   logic              rst_n;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              cfg_mode;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int                at;
      logic [NUM_CH-1:0] en;
      logic              valid;
      logic [CH_W-1:0]   ch;
      logic [CNT_W-1:0]  div;
      logic              mode;
      logic              exp_ready;
   } vec_t;

   typedef struct {
      int       e;
      logic [7:0] exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];

   clk_div_multi #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT),
      .CH_W     (CH_W)
   ) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_mode  (cfg_mode),
      .en        (en),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input int at, input logic [NUM_CH-1:0] en_v, input logic valid,
                          input logic [CH_W-1:0] ch, input int div, input logic mode,
                          input logic exp_ready);
      vec_t v;
      v.at        = at;
      v.en        = en_v;
      v.valid     = valid;
      v.ch        = ch;
      v.div       = CNT_W'(div);
      v.mode      = mode;
      v.exp_ready = exp_ready;
      vecs.push_back(v);
   endtask

   // Drive every vector scheduled just after edge 'at' and check cfg_ready.
   task automatic apply_vecs(input int at);
      foreach (vecs[i]) begin
         if (vecs[i].at == at) begin
            en        = vecs[i].en;
            cfg_valid = vecs[i].valid;
            cfg_ch    = vecs[i].ch;
            cfg_div   = vecs[i].div;
            cfg_mode  = vecs[i].mode;
            #1;
            check($sformatf("ready_e%0d_ch%0d", at, vecs[i].ch),
                  {31'd0, cfg_ready}, {31'd0, vecs[i].exp_ready});
         end
      end
   endtask

   // Expected {tick, clk_out} after edge e of the main scenario.
   //   ch0: square /100 throughout.
   //   ch1: tick /3 from edge 100 (square output forced low there).
   //   ch2: stopped over edges 41..50 where /5 applies, restarts at edge 51.
   //   ch3: D=0 clamps to 1 at edge 100 (toggles there, then every edge).
   function automatic logic [7:0] exp_main(input int e);
      logic [3:0] c;
      logic [3:0] t;
      c = '0;
      t = '0;
      c[0] = ((e / 100) % 2) == 1;
      if (e > 100) t[1] = ((e - 100) % 3) == 0;
      if (e >= 51) c[2] = (((e - 50) / 5) % 2) == 1;
      if (e >= 100) c[3] = ((e - 100) % 2) == 0;
      return {t, c};
   endfunction

   // After a mid-run reset every channel is back to square /100.
   function automatic logic [7:0] exp_after_reset(input int e);
      return (e >= 100) ? 8'h0F : 8'h00;
   endfunction

   task automatic run_edges(input int last, input bit main_phase);
      for (int e = 1; e <= last; e++) begin
         sb_t s;
         if (main_phase) apply_vecs(e - 1);
         s.e   = e;
         s.exp = main_phase ? exp_main(e) : exp_after_reset(e);
         sb_q.push_back(s);
         @(posedge clk_in);
         #1;
         if (sb_q.size() == 0) begin
            check($sformatf("sb_empty_e%0d", e), 32'd1, 32'd0);
         end else begin
            s = sb_q.pop_front();
            check($sformatf("out_e%0d", s.e), {24'd0, tick, clk_out}, {24'd0, s.exp});
         end
      end
   endtask

   initial begin
      // at, en, valid, ch, div, mode, expected cfg_ready
      add_vec( 29, 4'hF, 1'b1, 2'd1, 3, 1'b1, 1'b1);   // ch1 -> tick /3, accepted at edge 30
      add_vec( 30, 4'hF, 1'b1, 2'd1, 7, 1'b0, 1'b0);   // ch1 again while pending: refused
      add_vec( 31, 4'hF, 1'b1, 2'd2, 5, 1'b0, 1'b1);   // ch2 -> square /5 accepted
      add_vec( 32, 4'hF, 1'b1, 2'd3, 0, 1'b0, 1'b1);   // ch3 -> D=0 square accepted
      add_vec( 33, 4'hF, 1'b0, 2'd3, 0, 1'b0, 1'b0);   // ch3 now pending
      add_vec( 40, 4'hB, 1'b0, 2'd2, 0, 1'b0, 1'b0);   // stop ch2 while pending
      add_vec( 41, 4'hB, 1'b0, 2'd2, 0, 1'b0, 1'b1);   // ch2 applied on the stopped edge
      add_vec( 50, 4'hF, 1'b0, 2'd1, 0, 1'b0, 1'b0);   // restart ch2; ch1 still pending
      add_vec( 99, 4'hF, 1'b0, 2'd1, 0, 1'b0, 1'b0);   // one edge before ch1 terminal
      add_vec(100, 4'hF, 1'b0, 2'd1, 0, 1'b0, 1'b1);   // ch1 applied at its terminal
      add_vec(110, 4'hF, 1'b0, 2'd3, 0, 1'b0, 1'b1);   // ch3 applied at its terminal
      add_vec(140, 4'hF, 1'b1, 2'd0, 7, 1'b1, 1'b1);   // ch0 -> tick /7, to be lost by reset
      add_vec(141, 4'hF, 1'b0, 2'd0, 0, 1'b0, 1'b0);   // ch0 pending

      rst_n     = 1'b0;
      en        = 4'hF;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_mode  = 1'b0;
      #1;
      check("reset_clk_out", {28'd0, clk_out}, 32'd0);
      check("reset_tick", {28'd0, tick}, 32'd0);
      check("reset_ready", {31'd0, cfg_ready}, 32'd1);

      repeat (3) @(posedge clk_in);
      #1;
      rst_n = 1'b1;

      run_edges(150, 1'b1);

      // Asynchronous reset between edges: outputs clear before any edge and
      // the pending ch0 config is dropped.
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_clk_out", {28'd0, clk_out}, 32'd0);
      check("midrst_tick", {28'd0, tick}, 32'd0);
      check("midrst_ready_ch0", {31'd0, cfg_ready}, 32'd1);

      repeat (2) @(posedge clk_in);
      #1;
      rst_n     = 1'b1;
      cfg_valid = 1'b0;
      cfg_ch    = 2'd0;
      en        = 4'hF;
      #1;
      check("postrst_ready_ch0", {31'd0, cfg_ready}, 32'd1);

      run_edges(110, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
